multicycle_ctrl: RTL and testbench

Parametrised multi-cycle control unit for the 32-bit MIPS datapath, replacing the single-cycle registered decoder. A Moore state machine sequences each instruction through fetch, decode, execute, memory and write-back states. It issues one-cycle register-file and PC enables, and waits on a memory-ready handshake so instruction and data memories may take variable latency. The instruction set adds `bne`, `addi` and a bus-timeout trap.

---
 rtl/multicycle_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit: Moore sequencer with memory-ready handshake,
// bus-timeout trap and illegal-instruction trap.
module multicycle_ctrl #(
    parameter int unsigned ALUCTL_W = 11,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [5:0]          Op,
    input  logic [5:0]          Funct,
    input  logic                Zero,
    input  logic                MemReady,
    output logic                PCEn,
    output logic                IorD,
    output logic                RD,
    output logic                WD,
    output logic                IRWrite,
    output logic                RegDst,
    output logic                MemOrReg,
    output logic                RegWrite,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic                signext,
    output logic [1:0]          PCSrc,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic                Trap
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ALU_W = 4;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_ADDU = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUBU = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_NOR  = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'b1010;

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEMADR, S_MEMRD,
        S_MEMWB, S_MEMWR, S_WB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_ADDI, C_ORI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_ILL
    } cls_t;

    // Registered control word; the handshake-qualified enables are finished
    // combinationally from the fetch/branch flags below.
    typedef struct packed {
        logic             pc_load;
        logic             iord;
        logic             rd;
        logic             wd;
        logic             fetch;
        logic             reg_dst;
        logic             mem_or_reg;
        logic             reg_write;
        logic [1:0]       alu_src_a;
        logic [1:0]       alu_src_b;
        logic             signext;
        logic [1:0]       pc_src;
        logic [ALU_W-1:0] alu;
        logic             br_eq;
        logic             br_ne;
        logic             trap;
    } ctl_t;

    state_t           state;
    state_t           next_state;
    cls_t             cls;
    logic [ALU_W-1:0] r_alu;
    logic             r_shamt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             timed_out;
    logic             wait_state;
    ctl_t             ctl;
    ctl_t             nxt;

    // Instruction class and R-type ALU operation from the held instruction
    always_comb begin
        cls     = C_ILL;
        r_alu   = ALU_ADD;
        r_shamt = 1'b0;
        case (Op)
            6'b000000: begin
                cls = C_R;
                case (Funct)
                    6'b100000: r_alu = ALU_ADD;
                    6'b100001: r_alu = ALU_ADDU;
                    6'b100010: r_alu = ALU_SUB;
                    6'b100011: r_alu = ALU_SUBU;
                    6'b100100: r_alu = ALU_AND;
                    6'b100101: r_alu = ALU_OR;
                    6'b100110: r_alu = ALU_XOR;
                    6'b100111: r_alu = ALU_NOR;
                    6'b000000: begin r_alu = ALU_SLL; r_shamt = 1'b1; end
                    6'b000010: begin r_alu = ALU_SRL; r_shamt = 1'b1; end
                    6'b000011: begin r_alu = ALU_SRA; r_shamt = 1'b1; end
                    6'b000100: r_alu = ALU_SLL;
                    6'b000110: r_alu = ALU_SRL;
                    6'b000111: r_alu = ALU_SRA;
                    default:   cls = C_ILL;
                endcase
            end
            6'b001000: cls = C_ADDI;
            6'b001101: cls = C_ORI;
            6'b100011: cls = C_LW;
            6'b101011: cls = C_SW;
            6'b000100: cls = C_BEQ;
            6'b000101: cls = C_BNE;
            6'b000010: cls = C_J;
            default:   cls = C_ILL;
        endcase
    end

    assign wait_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timed_out  = (wait_cnt == CNT_W'(TIMEOUT));

    // Next-state sequencing; a completed handshake always beats the timeout
    always_comb begin
        next_state = state;
        case (state)
            S_RST:    next_state = S_FETCH;
            S_FETCH: begin
                if (MemReady)       next_state = S_DECODE;
                else if (timed_out) next_state = S_TRAP;
            end
            S_DECODE: begin
                case (cls)
                    C_R:           next_state = S_EXEC_R;
                    C_ADDI, C_ORI: next_state = S_EXEC_I;
                    C_LW, C_SW:    next_state = S_MEMADR;
                    C_BEQ, C_BNE:  next_state = S_BRANCH;
                    C_J:           next_state = S_JUMP;
                    default:       next_state = S_TRAP;
                endcase
            end
            S_EXEC_R: next_state = S_WB;
            S_EXEC_I: next_state = S_WB;
            S_MEMADR: next_state = (cls == C_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (MemReady)       next_state = S_MEMWB;
                else if (timed_out) next_state = S_TRAP;
            end
            S_MEMWR: begin
                if (MemReady)       next_state = S_FETCH;
                else if (timed_out) next_state = S_TRAP;
            end
            S_MEMWB:  next_state = S_FETCH;
            S_WB:     next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_TRAP:   next_state = S_TRAP;
            default:  next_state = S_RST;
        endcase
    end

    // Wait counter restarts on every entry to a memory state
    always_comb begin
        next_cnt = '0;
        if (wait_state && !MemReady && (next_state == state)) begin
            next_cnt = wait_cnt + CNT_W'(1);
        end
    end

    // Control word for the state being entered, so outputs align with state
    always_comb begin
        nxt = '0;
        case (next_state)
            S_FETCH: begin
                nxt.rd        = 1'b1;
                nxt.fetch     = 1'b1;
                nxt.alu_src_b = 2'b01;
                nxt.alu       = ALU_ADD;
            end
            S_DECODE: begin
                nxt.alu_src_b = 2'b11;
                nxt.signext   = 1'b1;
                nxt.alu       = ALU_ADD;
            end
            S_EXEC_R: begin
                nxt.alu_src_a = r_shamt ? 2'b10 : 2'b01;
                nxt.alu       = r_alu;
            end
            S_EXEC_I: begin
                nxt.alu_src_a = 2'b01;
                nxt.alu_src_b = 2'b10;
                nxt.signext   = (cls == C_ADDI);
                nxt.alu       = (cls == C_ADDI) ? ALU_ADD : ALU_OR;
            end
            S_MEMADR: begin
                nxt.alu_src_a = 2'b01;
                nxt.alu_src_b = 2'b10;
                nxt.signext   = 1'b1;
                nxt.alu       = ALU_ADD;
            end
            S_MEMRD: begin
                nxt.rd   = 1'b1;
                nxt.iord = 1'b1;
            end
            S_MEMWR: begin
                nxt.wd   = 1'b1;
                nxt.iord = 1'b1;
            end
            S_MEMWB: begin
                nxt.reg_write  = 1'b1;
                nxt.mem_or_reg = 1'b1;
            end
            S_WB: begin
                nxt.reg_write = 1'b1;
                nxt.reg_dst   = (cls == C_R);
            end
            S_BRANCH: begin
                nxt.alu_src_a = 2'b01;
                nxt.alu       = ALU_SUB;
                nxt.pc_src    = 2'b01;
                nxt.br_eq     = (cls == C_BEQ);
                nxt.br_ne     = (cls == C_BNE);
            end
            S_JUMP: begin
                nxt.pc_src  = 2'b11;
                nxt.pc_load = 1'b1;
            end
            S_TRAP:  nxt.trap = 1'b1;
            default: nxt = '0;
        endcase
    end

    // State, wait counter and control word registers
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state    <= S_RST;
            wait_cnt <= '0;
            ctl      <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
            ctl      <= nxt;
        end
    end

    // Handshake/flag-qualified enables are suppressed while reset is applied
    assign IRWrite    = reset & ctl.fetch & MemReady;
    assign PCEn       = reset & (ctl.pc_load | (ctl.fetch & MemReady)
                                 | (ctl.br_eq & Zero) | (ctl.br_ne & ~Zero));
    assign IorD       = ctl.iord;
    assign RD         = ctl.rd;
    assign WD         = ctl.wd;
    assign RegDst     = ctl.reg_dst;
    assign MemOrReg   = ctl.mem_or_reg;
    assign RegWrite   = ctl.reg_write;
    assign ALUSrcA    = ctl.alu_src_a;
    assign ALUSrcB    = ctl.alu_src_b;
    assign signext    = ctl.signext;
    assign PCSrc      = ctl.pc_src;
    assign ALUControl = ALUCTL_W'(ctl.alu);
    assign Trap       = ctl.trap;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl.
module tb_multicycle_ctrl;

    logic        CLK;
    logic        rst_n;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        Zero;
    logic        MemReady;
    logic        PCEn, IorD, RD, WD, IRWrite, RegDst, MemOrReg, RegWrite;
    logic [1:0]  ALUSrcA, ALUSrcB, PCSrc;
    logic        signext, Trap;
    logic [10:0] ALUControl;

    int n_total = 0;
    int n_pass  = 0;

    multicycle_ctrl dut (
        .CLK(CLK), .reset(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .PCEn(PCEn), .IorD(IorD), .RD(RD), .WD(WD),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemOrReg(MemOrReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .signext(signext), .PCSrc(PCSrc), .ALUControl(ALUControl), .Trap(Trap)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        pcen, iord, rd, wd, irw, rdst, mor, rw;
        logic [1:0]  srca, srcb;
        logic        sext;
        logic [1:0]  pcsrc;
        logic [10:0] alu;
        logic        trap;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         ncyc;
        int         chk;
        outs_t      exp;
    } vec_t;

    function automatic outs_t o(logic pcen, logic iord, logic rd, logic wd,
                                logic irw, logic rdst, logic mor, logic rw,
                                logic [1:0] srca, logic [1:0] srcb, logic sext,
                                logic [1:0] pcsrc, logic [3:0] alu, logic trap);
        outs_t r;
        r.pcen = pcen; r.iord = iord; r.rd = rd; r.wd = wd; r.irw = irw;
        r.rdst = rdst; r.mor = mor; r.rw = rw; r.srca = srca; r.srcb = srcb;
        r.sext = sext; r.pcsrc = pcsrc; r.alu = 11'(alu); r.trap = trap;
        return r;
    endfunction

    function automatic outs_t snap();
        outs_t r;
        r.pcen = PCEn; r.iord = IorD; r.rd = RD; r.wd = WD; r.irw = IRWrite;
        r.rdst = RegDst; r.mor = MemOrReg; r.rw = RegWrite; r.srca = ALUSrcA;
        r.srcb = ALUSrcB; r.sext = signext; r.pcsrc = PCSrc; r.alu = ALUControl;
        r.trap = Trap;
        return r;
    endfunction

    task automatic check(input string name, input outs_t got, input outs_t exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %07h expected %07h", name, got, exp);
        else
            n_pass++;
    endtask

    // One clock: drive inputs just after the edge, sample at the falling edge
    task automatic rc(input logic r, input logic rdy, input logic z, output outs_t ob);
        @(posedge CLK);
        #1;
        rst_n    = r;
        MemReady = rdy;
        Zero     = z;
        @(negedge CLK);
        ob = snap();
    endtask

    outs_t F_RDY, F_WAIT, DEC, ZERO_O, TRAP_O, MRD, MWR;
    vec_t  vecs[20];
    outs_t ob;

    initial begin
        F_RDY  = o(1,0,1,0,1,0,0,0,2'b00,2'b01,0,2'b00,4'h0,0);
        F_WAIT = o(0,0,1,0,0,0,0,0,2'b00,2'b01,0,2'b00,4'h0,0);
        DEC    = o(0,0,0,0,0,0,0,0,2'b00,2'b11,1,2'b00,4'h0,0);
        ZERO_O = '0;
        TRAP_O = o(0,0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,4'h0,1);
        MRD    = o(0,1,1,0,0,0,0,0,2'b00,2'b00,0,2'b00,4'h0,0);
        MWR    = o(0,1,0,1,0,0,0,0,2'b00,2'b00,0,2'b00,4'h0,0);

        vecs[0]  = '{6'h00, 6'h20, 1'b0, 4, 3, o(0,0,0,0,0,0,0,0,2'b01,2'b00,0,2'b00,4'h0,0)};
        vecs[1]  = '{6'h00, 6'h22, 1'b0, 4, 3, o(0,0,0,0,0,0,0,0,2'b01,2'b00,0,2'b00,4'h2,0)};
        vecs[2]  = '{6'h00, 6'h27, 1'b0, 4, 3, o(0,0,0,0,0,0,0,0,2'b01,2'b00,0,2'b00,4'h7,0)};
        vecs[3]  = '{6'h00, 6'h00, 1'b0, 4, 3, o(0,0,0,0,0,0,0,0,2'b10,2'b00,0,2'b00,4'h8,0)};
        vecs[4]  = '{6'h00, 6'h03, 1'b0, 4, 3, o(0,0,0,0,0,0,0,0,2'b10,2'b00,0,2'b00,4'hA,0)};
        vecs[5]  = '{6'h00, 6'h07, 1'b0, 4, 3, o(0,0,0,0,0,0,0,0,2'b01,2'b00,0,2'b00,4'hA,0)};
        vecs[6]  = '{6'h00, 6'h20, 1'b0, 4, 4, o(0,0,0,0,0,1,0,1,2'b00,2'b00,0,2'b00,4'h0,0)};
        vecs[7]  = '{6'h08, 6'h00, 1'b0, 4, 3, o(0,0,0,0,0,0,0,0,2'b01,2'b10,1,2'b00,4'h0,0)};
        vecs[8]  = '{6'h0D, 6'h00, 1'b0, 4, 3, o(0,0,0,0,0,0,0,0,2'b01,2'b10,0,2'b00,4'h5,0)};
        vecs[9]  = '{6'h0D, 6'h00, 1'b0, 4, 4, o(0,0,0,0,0,0,0,1,2'b00,2'b00,0,2'b00,4'h0,0)};
        vecs[10] = '{6'h2B, 6'h00, 1'b0, 4, 3, o(0,0,0,0,0,0,0,0,2'b01,2'b10,1,2'b00,4'h0,0)};
        vecs[11] = '{6'h2B, 6'h00, 1'b0, 4, 4, MWR};
        vecs[12] = '{6'h23, 6'h00, 1'b0, 5, 4, MRD};
        vecs[13] = '{6'h23, 6'h00, 1'b0, 5, 5, o(0,0,0,0,0,0,1,1,2'b00,2'b00,0,2'b00,4'h0,0)};
        vecs[14] = '{6'h04, 6'h00, 1'b1, 3, 3, o(1,0,0,0,0,0,0,0,2'b01,2'b00,0,2'b01,4'h2,0)};
        vecs[15] = '{6'h04, 6'h00, 1'b0, 3, 3, o(0,0,0,0,0,0,0,0,2'b01,2'b00,0,2'b01,4'h2,0)};
        vecs[16] = '{6'h05, 6'h00, 1'b0, 3, 3, o(1,0,0,0,0,0,0,0,2'b01,2'b00,0,2'b01,4'h2,0)};
        vecs[17] = '{6'h05, 6'h00, 1'b1, 3, 3, o(0,0,0,0,0,0,0,0,2'b01,2'b00,0,2'b01,4'h2,0)};
        vecs[18] = '{6'h02, 6'h00, 1'b0, 3, 3, o(1,0,0,0,0,0,0,0,2'b00,2'b00,0,2'b11,4'h0,0)};
        vecs[19] = '{6'h08, 6'h00, 1'b0, 4, 2, DEC};

        rst_n = 1'b0; MemReady = 1'b1; Zero = 1'b0; Op = 6'h23; Funct = 6'h00;

        // Reset, first fetch, then lw with three MemReady-low cycles in MEMRD
        rc(1'b0, 1'b1, 1'b0, ob); check("in_reset", ob, ZERO_O);
        rc(1'b1, 1'b1, 1'b0, ob); check("after_reset", ob, ZERO_O);
        rc(1'b1, 1'b1, 1'b0, ob); check("first_fetch", ob, F_RDY);
        rc(1'b1, 1'b1, 1'b0, ob); check("lw_decode", ob, DEC);
        rc(1'b1, 1'b1, 1'b0, ob);
        rc(1'b1, 1'b0, 1'b0, ob); check("lw_wait1", ob, MRD);
        rc(1'b1, 1'b0, 1'b0, ob);
        rc(1'b1, 1'b0, 1'b0, ob);
        rc(1'b1, 1'b1, 1'b0, ob); check("lw_ready", ob, MRD);
        rc(1'b1, 1'b1, 1'b0, ob);
        check("lw_memwb_c8", ob, o(0,0,0,0,0,0,1,1,2'b00,2'b00,0,2'b00,4'h0,0));

        // Table of single instructions with MemReady always high
        for (int i = 0; i < 20; i++) begin
            Op    = vecs[i].op;
            Funct = vecs[i].funct;
            for (int c = 1; c <= vecs[i].ncyc; c++) begin
                rc(1'b1, 1'b1, vecs[i].zero, ob);
                if (c == 1) check($sformatf("vec%0d_fetch", i), ob, F_RDY);
                if (c == vecs[i].chk) check($sformatf("vec%0d_c%0d", i, c), ob, vecs[i].exp);
            end
        end

        // Illegal opcode traps after DECODE and stays trapped until reset
        Op = 6'h3F; Funct = 6'h00;
        rc(1'b1, 1'b1, 1'b0, ob); check("ill_fetch", ob, F_RDY);
        rc(1'b1, 1'b1, 1'b0, ob); check("ill_decode", ob, DEC);
        rc(1'b1, 1'b1, 1'b0, ob); check("ill_trap", ob, TRAP_O);
        for (int k = 0; k < 4; k++) begin
            rc(1'b1, k[0], k[1], ob);
            check($sformatf("ill_sticky%0d", k), ob, TRAP_O);
        end
        rc(1'b0, 1'b1, 1'b0, ob);
        rc(1'b1, 1'b1, 1'b0, ob); check("ill_reset_clears", ob, ZERO_O);

        // Bus timeout: 16 MemReady-low cycles in FETCH trap
        Op = 6'h00; Funct = 6'h20;
        for (int k = 1; k <= 16; k++) begin
            rc(1'b1, 1'b0, 1'b0, ob);
            if (k == 1 || k == 16) check($sformatf("to_wait%0d", k), ob, F_WAIT);
        end
        rc(1'b1, 1'b1, 1'b0, ob); check("to_trap", ob, TRAP_O);
        rc(1'b0, 1'b1, 1'b0, ob);
        rc(1'b1, 1'b1, 1'b0, ob); check("to_reset", ob, ZERO_O);

        // Ready on the 16th cycle completes the fetch with no trap
        for (int k = 1; k <= 15; k++) rc(1'b1, 1'b0, 1'b0, ob);
        rc(1'b1, 1'b1, 1'b0, ob); check("edge_fetch", ob, F_RDY);
        rc(1'b1, 1'b1, 1'b0, ob); check("edge_decode", ob, DEC);
        rc(1'b1, 1'b1, 1'b0, ob);
        rc(1'b1, 1'b1, 1'b0, ob);
        check("edge_wb", ob, o(0,0,0,0,0,1,0,1,2'b00,2'b00,0,2'b00,4'h0,0));

        // Reset during a store wait aborts with all outputs low
        Op = 6'h2B; Funct = 6'h00;
        rc(1'b1, 1'b1, 1'b0, ob);
        rc(1'b1, 1'b1, 1'b0, ob);
        rc(1'b1, 1'b1, 1'b0, ob);
        rc(1'b1, 1'b0, 1'b0, ob); check("sw_wait", ob, MWR);
        rc(1'b0, 1'b0, 1'b0, ob); check("sw_wait_hold", ob, MWR);
        rc(1'b1, 1'b1, 1'b0, ob); check("sw_abort", ob, ZERO_O);
        rc(1'b1, 1'b1, 1'b0, ob); check("refetch", ob, F_RDY);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
